// File: rtl/alu_issue.sv
// ALU issue stage: decodes R/I-type instruction fields into an ALU operation
// and hands it downstream through a two-entry skid buffer.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_alufunc,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic             out_signed,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // state | meaning
  // EMPTY | no entry held, out_valid low
  // ONE   | head entry on out_*, skid slot free
  // TWO   | head on out_*, skid slot holds the next entry; input stalled
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        ill;
  } entry_t;

  state_t state, state_nxt;
  entry_t dec, head, skid;
  logic   in_xfer, out_xfer;
  logic   load_head_in, load_head_skid, load_skid;

  logic [31:0] imm_sx, imm_zx, shamt_zx;
  assign imm_sx   = {{16{in_imm[15]}}, in_imm};
  assign imm_zx   = {16'h0000, in_imm};
  assign shamt_zx = {27'd0, in_shamt};

  always_comb begin
    dec = '{func: 6'b000000, a: 32'd0, b: 32'd0, sgn: 1'b0, ill: 1'b1};
    case (in_opcode)
      6'h00: begin
        case (in_funct)
          6'h20: dec = '{6'b000000, in_rs,    in_rt, 1'b1, 1'b0};
          6'h21: dec = '{6'b000000, in_rs,    in_rt, 1'b0, 1'b0};
          6'h22: dec = '{6'b000001, in_rs,    in_rt, 1'b1, 1'b0};
          6'h23: dec = '{6'b000001, in_rs,    in_rt, 1'b0, 1'b0};
          6'h24: dec = '{6'b011000, in_rs,    in_rt, 1'b0, 1'b0};
          6'h25: dec = '{6'b011110, in_rs,    in_rt, 1'b0, 1'b0};
          6'h26: dec = '{6'b010110, in_rs,    in_rt, 1'b0, 1'b0};
          6'h27: dec = '{6'b010001, in_rs,    in_rt, 1'b0, 1'b0};
          6'h2A: dec = '{6'b110101, in_rs,    in_rt, 1'b1, 1'b0};
          6'h00: dec = '{6'b100000, shamt_zx, in_rt, 1'b0, 1'b0};
          6'h02: dec = '{6'b100001, shamt_zx, in_rt, 1'b0, 1'b0};
          6'h03: dec = '{6'b100011, shamt_zx, in_rt, 1'b0, 1'b0};
          default: ;
        endcase
      end
      6'h08: dec = '{6'b000000, in_rs, imm_sx, 1'b1, 1'b0};
      6'h09: dec = '{6'b000000, in_rs, imm_sx, 1'b0, 1'b0};
      6'h0A: dec = '{6'b110101, in_rs, imm_sx, 1'b1, 1'b0};
      6'h0C: dec = '{6'b011000, in_rs, imm_zx, 1'b0, 1'b0};
      6'h0D: dec = '{6'b011110, in_rs, imm_zx, 1'b0, 1'b0};
      6'h0E: dec = '{6'b010110, in_rs, imm_zx, 1'b0, 1'b0};
      6'h0F: dec = '{6'b011010, {in_imm, 16'h0000}, 32'd0, 1'b0, 1'b0};
      default: ;
    endcase
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        state_nxt    = ONE;
        load_head_in = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        state_nxt      = ONE;
        load_head_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready    <= 1'b0;
      head        <= '0;
      skid        <= '0;
      illegal_cnt <= '0;
    end else begin
      state    <= state_nxt;
      // registered ready looks one state ahead so no transfer lands in TWO
      in_ready <= (state_nxt != TWO);
      if (load_head_in)        head <= dec;
      else if (load_head_skid) head <= skid;
      if (load_skid)           skid <= dec;
      if (in_xfer && dec.ill && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_alufunc = head.func;
  assign out_a       = head.a;
  assign out_b       = head.b;
  assign out_signed  = head.sgn;
  assign out_illegal = head.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: decode values, skid-buffer flow
// control, illegal counter saturation and asynchronous reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_alufunc;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_signed;
  logic        out_illegal;
  logic [1:0]  illegal_cnt;

  int nvec = 0;
  int nerr = 0;

  alu_issue #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alufunc(out_alufunc), .out_a(out_a), .out_b(out_b),
    .out_signed(out_signed), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic il);
    chk({tag, ".valid"},   32'(out_valid),   32'd1);
    chk({tag, ".func"},    32'(out_alufunc), 32'(f));
    chk({tag, ".a"},       out_a,            a);
    chk({tag, ".b"},       out_b,            b);
    chk({tag, ".signed"},  32'(out_signed),  32'(s));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(il));
  endtask

  task automatic offer(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct  = fn;
    in_shamt  = sh;
    in_imm    = imm;
    in_rs     = rs;
    in_rt     = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_funct = '0; in_shamt = '0;
    in_imm = '0; in_rs = '0; in_rt = '0; out_ready = 1'b1;
    #2;
    chk("rst.out_valid", 32'(out_valid),   32'd0);
    chk("rst.in_ready",  32'(in_ready),    32'd0);
    chk("rst.cnt",       32'(illegal_cnt), 32'd0);
    chk("rst.func",      32'(out_alufunc), 32'd0);
    chk("rst.a",         out_a,            32'd0);
    #20 reset = 1'b0;
    step();
    chk("rel.in_ready", 32'(in_ready), 32'd1);

    // ori, latency 1
    offer(6'h0D, 6'h00, 5'd0, 16'h8001, 32'h0000_0010, 32'h0);
    step();
    in_valid = 1'b0;
    chk_out("ori", 6'b011110, 32'h0000_0010, 32'h0000_8001, 1'b0, 1'b0);

    // addi then lui back-to-back
    step();
    chk("idle1.valid", 32'(out_valid), 32'd0);
    offer(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'h0);
    step();
    chk_out("addi", 6'b000000, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    offer(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'h0);
    step();
    chk_out("lui", 6'b011010, 32'h1234_0000, 32'h0, 1'b0, 1'b0);

    offer(6'h00, 6'h03, 5'd4, 16'h0000, 32'h0, 32'h8000_0000);
    step();
    chk_out("sra", 6'b100011, 32'h4, 32'h8000_0000, 1'b0, 1'b0);
    offer(6'h00, 6'h22, 5'd0, 16'h0000, 32'd9, 32'd3);
    step();
    chk_out("sub", 6'b000001, 32'd9, 32'd3, 1'b1, 1'b0);
    offer(6'h0C, 6'h00, 5'd0, 16'hF00F, 32'h1, 32'h0);
    step();
    chk_out("andi", 6'b011000, 32'h1, 32'h0000_F00F, 1'b0, 1'b0);
    offer(6'h00, 6'h2A, 5'd0, 16'h0000, 32'hFFFF_FFFE, 32'd2);
    step();
    chk_out("slt", 6'b110101, 32'hFFFF_FFFE, 32'd2, 1'b1, 1'b0);
    offer(6'h0A, 6'h00, 5'd0, 16'h8000, 32'd7, 32'h0);
    step();
    chk_out("slti", 6'b110101, 32'd7, 32'hFFFF_8000, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("idle2.valid", 32'(out_valid), 32'd0);

    // backpressure: three offered, two held
    out_ready = 1'b0;
    offer(6'h0D, 6'h00, 5'd0, 16'h0001, 32'd1, 32'h0);
    step();
    offer(6'h0D, 6'h00, 5'd0, 16'h0002, 32'd2, 32'h0);
    step();
    offer(6'h0D, 6'h00, 5'd0, 16'h0003, 32'd3, 32'h0);
    step();
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    chk_out("bp.hold1", 6'b011110, 32'd1, 32'd1, 1'b0, 1'b0);
    step();
    chk("bp.in_ready2", 32'(in_ready), 32'd0);
    chk_out("bp.hold2", 6'b011110, 32'd1, 32'd1, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("bp.second", 6'b011110, 32'd2, 32'd2, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk_out("bp.third", 6'b011110, 32'd3, 32'd3, 1'b0, 1'b0);
    step();
    chk("bp.drained", 32'(out_valid), 32'd0);

    // illegal counter saturation at CNT_W=2
    offer(6'h3F, 6'h00, 5'd0, 16'h1234, 32'h5555_5555, 32'h6666_6666);
    step();
    chk_out("ill1", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("ill1.cnt", 32'(illegal_cnt), 32'd1);
    step();
    chk_out("ill2", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("ill2.cnt", 32'(illegal_cnt), 32'd2);
    step();
    chk_out("ill3", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("ill3.cnt", 32'(illegal_cnt), 32'd3);
    step();
    chk("ill4.cnt", 32'(illegal_cnt), 32'd3);
    offer(6'h00, 6'h02, 5'd31, 16'h0000, 32'h0, 32'hFFFF_0000);
    step();
    in_valid = 1'b0;
    chk_out("srl", 6'b100001, 32'd31, 32'hFFFF_0000, 1'b0, 1'b0);
    chk("srl.cnt", 32'(illegal_cnt), 32'd3);
    step();

    // asynchronous reset while two entries are held
    out_ready = 1'b0;
    offer(6'h0D, 6'h00, 5'd0, 16'h0000, 32'd7, 32'h0);
    step();
    offer(6'h0D, 6'h00, 5'd0, 16'h0000, 32'd8, 32'h0);
    step();
    in_valid = 1'b0;
    chk("two.in_ready", 32'(in_ready), 32'd0);
    chk("two.valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.out_valid", 32'(out_valid),   32'd0);
    chk("arst.in_ready",  32'(in_ready),    32'd0);
    chk("arst.cnt",       32'(illegal_cnt), 32'd0);
    chk("arst.a",         out_a,            32'd0);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post.in_ready", 32'(in_ready), 32'd1);
    chk("post.no_stale", 32'(out_valid), 32'd0);
    offer(6'h0D, 6'h00, 5'd0, 16'h0000, 32'd9, 32'h0);
    step();
    in_valid = 1'b0;
    chk_out("post.first", 6'b011110, 32'd9, 32'd0, 1'b0, 1'b0);
    step();
    chk("post.drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
